// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 tap shift
// register, emitting every fully interior window over a valid/ready handshake.
module window_gen_3x3 #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIX_W-1:0]         in_pix,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic [9*PIX_W-1:0]       win_out,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] taps_q [3][3];
  logic [PIX_W-1:0] taps_d [3][3];

  logic             accept;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic [CW-1:0]    col_n;
  logic [RW-1:0]    row_n;
  logic [PIX_W-1:0] top_px;
  logic [PIX_W-1:0] mid_px;
  logic             last_col;
  logic             last_row;
  logic             emit;
  logic [9*PIX_W-1:0] win_flat;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign cur_col  = in_sof ? '0 : col_q;
  assign cur_row  = in_sof ? '0 : row_q;
  assign last_col = (cur_col == COL_LAST);
  assign last_row = (cur_row == ROW_LAST);
  assign emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_comb begin
    top_px = lb1[cur_col];
    mid_px = lb0[cur_col];
  end

  always_comb begin
    col_n = cur_col + CW'(1);
    row_n = cur_row;
    if (last_col) begin
      col_n = '0;
      row_n = last_row ? '0 : cur_row + RW'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 2; j++) begin
        taps_d[i][j] = taps_q[i][j+1];
      end
    end
    taps_d[0][2] = top_px;
    taps_d[1][2] = mid_px;
    taps_d[2][2] = in_pix;
  end

  // Row-major packing: tap (0,0) lands in the most significant slice.
  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        win_flat[(8 - (i*3 + j))*PIX_W +: PIX_W] = taps_d[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb1[cur_col] <= mid_px;
      lb0[cur_col] <= in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      taps_q     <= '{default: '0};
      win_valid  <= 1'b0;
      win_out    <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
      if (accept) begin
        col_q  <= col_n;
        row_q  <= row_n;
        taps_q <= taps_d;
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_out   <= win_flat;
        win_row   <= cur_row - RW'(1);
        win_col   <= cur_col - CW'(1);
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: three image geometries share one stimulus/check
// path, with windows predicted directly from the generated image.
module tb_window_gen_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_sof, win_ready;
  logic [7:0] in_pix;
  int         sel;

  logic        a_iv, a_wr, a_ir, a_wv, a_fd;
  logic [71:0] a_wo;
  logic [1:0]  a_row, a_col;
  logic        b_iv, b_wr, b_ir, b_wv, b_fd;
  logic [71:0] b_wo;
  logic [2:0]  b_row, b_col;
  logic        c_iv, c_wr, c_ir, c_wv, c_fd;
  logic [71:0] c_wo;
  logic [1:0]  c_row, c_col;

  assign a_iv = in_valid && (sel == 0);
  assign b_iv = in_valid && (sel == 1);
  assign c_iv = in_valid && (sel == 2);
  assign a_wr = (sel == 0) ? win_ready : 1'b1;
  assign b_wr = (sel == 1) ? win_ready : 1'b1;
  assign c_wr = (sel == 2) ? win_ready : 1'b1;

  window_gen_3x3 #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(a_iv), .in_sof(in_sof),
    .in_ready(a_ir), .win_out(a_wo), .win_valid(a_wv), .win_ready(a_wr),
    .win_row(a_row), .win_col(a_col), .frame_done(a_fd));

  window_gen_3x3 #(.PIX_W(8), .IMG_W(8), .IMG_H(6)) u_b (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(b_iv), .in_sof(in_sof),
    .in_ready(b_ir), .win_out(b_wo), .win_valid(b_wv), .win_ready(b_wr),
    .win_row(b_row), .win_col(b_col), .frame_done(b_fd));

  window_gen_3x3 #(.PIX_W(8), .IMG_W(3), .IMG_H(3)) u_c (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(c_iv), .in_sof(in_sof),
    .in_ready(c_ir), .win_out(c_wo), .win_valid(c_wv), .win_ready(c_wr),
    .win_row(c_row), .win_col(c_col), .frame_done(c_fd));

  logic        o_in_ready, o_win_valid, o_frame_done;
  logic [71:0] o_win_out;
  logic [2:0]  o_win_row, o_win_col;

  always_comb begin
    o_in_ready   = a_ir;
    o_win_valid  = a_wv;
    o_frame_done = a_fd;
    o_win_out    = a_wo;
    o_win_row    = {1'b0, a_row};
    o_win_col    = {1'b0, a_col};
    if (sel == 1) begin
      o_in_ready   = b_ir;
      o_win_valid  = b_wv;
      o_frame_done = b_fd;
      o_win_out    = b_wo;
      o_win_row    = b_row;
      o_win_col    = b_col;
    end else if (sel == 2) begin
      o_in_ready   = c_ir;
      o_win_valid  = c_wv;
      o_frame_done = c_fd;
      o_win_out    = c_wo;
      o_win_row    = {1'b0, c_row};
      o_win_col    = {1'b0, c_col};
    end
  end

  typedef struct { logic [7:0] pix; bit sof; bit emit; bit last; } pix_t;
  typedef struct { logic [71:0] win; int row; int col; } win_t;

  pix_t pix_q[$];
  win_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   fd_cnt = 0;
  bit   prev_acc = 0, prev_emit = 0, prev_last = 0, hold_chk = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the first n pixels of a w x h frame and every window whose
  // bottom-right pixel falls within those n.
  task automatic add_frame(input int w, input int h, input int n, input bit rnd, input bit sof);
    logic [7:0]  img [0:5][0:7];
    logic [71:0] win;
    pix_t        p;
    win_t        e;
    for (int idx = 0; idx < n; idx++) begin
      int r = idx / w;
      int c = idx % w;
      img[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'(r*w + c);
      p.pix  = img[r][c];
      p.sof  = sof && (idx == 0);
      p.emit = (r >= 2) && (c >= 2);
      p.last = (idx == w*h - 1);
      pix_q.push_back(p);
    end
    for (int r = 1; r <= h-2; r++) begin
      for (int c = 1; c <= w-2; c++) begin
        if ((r+1)*w + (c+1) < n) begin
          win = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              win[(8 - (dr*3 + dc))*8 +: 8] = img[r-1+dr][c-1+dc];
          e.win = win; e.row = r; e.col = c;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (prev_acc) check("win_valid_after_accept", 72'(o_win_valid), 72'(prev_emit));
    check("frame_done_timing", 72'(o_frame_done), 72'(prev_last));
    if (hold_chk && exp_q.size() > 0) begin
      check("hold_in_ready", 72'(o_in_ready), 72'(0));
      check("hold_win_out", o_win_out, exp_q[0].win);
    end
    if (o_win_valid && win_ready) begin
      check("window_expected", 72'(exp_q.size() > 0), 72'(1));
      if (exp_q.size() > 0) begin
        check("win_out", o_win_out, exp_q[0].win);
        check("win_row", 72'(o_win_row), 72'(exp_q[0].row));
        check("win_col", 72'(o_win_col), 72'(exp_q[0].col));
        void'(exp_q.pop_front());
      end
    end
    if (o_frame_done) fd_cnt++;
    prev_acc  = in_valid && o_in_ready && !rst;
    prev_last = 1'b0;
    if (prev_acc && pix_q.size() > 0) begin
      prev_emit = pix_q[0].emit;
      prev_last = pix_q[0].last;
      void'(pix_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // wrmode: 0 = win_ready held high, 1 = random, 2 = held low.
  task automatic run(input int wrmode, input bit stall5, input bit wait_exp, input int max_cyc);
    int cyc = 0;
    int stall_left = 0;
    bit stall_done = 0;
    while ((pix_q.size() > 0 || (wait_exp && exp_q.size() > 0)) && cyc < max_cyc) begin
      if (pix_q.size() > 0) begin
        in_valid = (wrmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_pix   = pix_q[0].pix;
        in_sof   = pix_q[0].sof;
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      if (stall5 && !stall_done && o_win_valid) begin
        stall_done = 1;
        stall_left = 5;
      end
      hold_chk = (stall_left > 0);
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = (wrmode == 0) ? 1'b1 : (wrmode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
      cycle();
      hold_chk = 0;
      cyc++;
    end
    check("run_within_budget", 72'(cyc < max_cyc), 72'(1));
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (wait_exp) begin
      win_ready = 1'b1;
      repeat (2) cycle();
      check("windows_outstanding", 72'(exp_q.size()), 72'(0));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; win_ready = 1'b1; sel = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_win_valid", 72'(o_win_valid), 72'(0));
    check("rst_win_out", o_win_out, 72'(0));
    check("rst_win_row", 72'(o_win_row), 72'(0));
    check("rst_win_col", 72'(o_win_col), 72'(0));
    check("rst_frame_done", 72'(o_frame_done), 72'(0));
    check("rst_in_ready", 72'(o_in_ready), 72'(1));
    @(posedge clk); #1;

    // 4x4 ramp, free-flowing
    sel = 0; fd_cnt = 0;
    add_frame(4, 4, 16, 0, 1);
    run(0, 0, 1, 200);
    check("t1_frame_done_count", 72'(fd_cnt), 72'(1));

    // same image with a 5-cycle stall on the first window
    fd_cnt = 0;
    add_frame(4, 4, 16, 0, 1);
    run(0, 1, 1, 200);
    check("t2_frame_done_count", 72'(fd_cnt), 72'(1));

    // 8x6, random handshakes, two frames back to back
    sel = 1; fd_cnt = 0;
    add_frame(8, 6, 48, 1, 1);
    add_frame(8, 6, 48, 1, 1);
    run(1, 0, 1, 3000);
    check("t3_frame_done_count", 72'(fd_cnt), 72'(2));

    // frame aborted by a start-of-frame at pixel 9
    sel = 0; fd_cnt = 0;
    add_frame(4, 4, 9, 1, 1);
    add_frame(4, 4, 16, 1, 1);
    run(0, 0, 1, 300);
    check("t4_frame_done_count", 72'(fd_cnt), 72'(1));

    // reset while a window is stalled
    fd_cnt = 0;
    add_frame(4, 4, 11, 0, 1);
    run(2, 0, 0, 100);
    rst = 1'b1; win_ready = 1'b0;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t5_win_valid", 72'(o_win_valid), 72'(0));
    check("t5_in_ready", 72'(o_in_ready), 72'(1));
    check("t5_frame_done", 72'(o_frame_done), 72'(0));
    @(posedge clk); #1;
    exp_q.delete();
    pix_q.delete();
    prev_acc = 0; prev_last = 0;
    add_frame(4, 4, 16, 0, 0);
    run(1, 0, 1, 500);
    check("t5_frame_done_count", 72'(fd_cnt), 72'(1));

    // 3x3: a single window
    sel = 2; fd_cnt = 0;
    add_frame(3, 3, 9, 0, 1);
    run(0, 0, 1, 100);
    check("t6_frame_done_count", 72'(fd_cnt), 72'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Parametrised streaming 3x3 neighbourhood generator. Successor to the fixed 72-bit window reader that feeds main_sobel.
- Accepts a raster pixel stream one pixel per handshake and keeps two line buffers of depth IMG_W.
- Emits each fully interior 3x3 window with a valid/ready handshake. Supports backpressure, start-of-frame resync and an end-of-frame pulse.

Parameters:
- PIX_W, 8, bits per pixel
- IMG_W, 64, pixels per line (>=3)
- IMG_H, 64, lines per frame (>=3)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_pix  input  PIX_W  incoming pixel, raster order
- in_valid  input  1  in_pix is valid
- in_sof  input  1  qualifies in_valid; this pixel is (row 0, col 0)
- in_ready  output  1  block can accept a pixel this cycle
- win_out  output  9*PIX_W  window, row-major, top-left in the MSB slice, bottom-right in the LSB slice
- win_valid  output  1  win_out holds a window
- win_ready  input  1  downstream accepts win_out this cycle
- win_row  output  clog2(IMG_H)  centre row of win_out
- win_col  output  clog2(IMG_W)  centre column of win_out
- frame_done  output  1  one-cycle pulse, last pixel of frame accepted

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Accept condition: accept = in_valid && in_ready.
- Ready rule: in_ready = !win_valid || win_ready. This is combinational from registered state and win_ready. There is no skid buffer.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel to accept.
  - On accept, col increments.
  - When col = IMG_W-1, col wraps to 0 and row increments.
  - When col = IMG_W-1 and row = IMG_H-1, both wrap to 0.
- in_sof on accept: the pixel is treated as (0,0) regardless of the counters, and the counters become (0,1).
  - A partial previous frame is abandoned; no frame_done is generated for it.
  - in_sof at (0,0) is harmless.
- Line buffers: two RAMs or arrays of IMG_W x PIX_W.
  - On accept at column c, lb1[c] is read (pixel from row-2) and lb0[c] is read (row-1).
  - Then lb1[c] <= lb0[c] and lb0[c] <= in_pix.
  - Line buffer contents are not reset.
- Tap registers: a 3x3 shift register, shifted left by one column on each accept.
  - New right column = {lb1[c], lb0[c], in_pix}, top to bottom.
  - Tap registers shift across line boundaries; the window gate below excludes the invalid windows this produces.
- Window emit: when the accepted pixel is at (r,c) with r>=2 and c>=2:
  - Next cycle, win_valid=1 and win_out = taps after the shift.
  - win_row = r-1, win_col = c-1.
- Latency: one cycle from accepting pixel (r,c) to the corresponding win_valid.
- Hold rule: while win_valid && !win_ready, win_out, win_row, win_col and win_valid hold. in_ready=0, so no overwrite is possible.
- Clear rule: on win_ready with no new window, win_valid clears.
- Back-to-back: a simultaneous win_ready and new emitting accept keeps win_valid=1 with new data.
- Window count per frame: (IMG_W-2)*(IMG_H-2). Columns 0..1 and rows 0..1 never emit.
- frame_done:
  - Pulses for one cycle, the cycle after accepting (IMG_H-1, IMG_W-1).
  - Coincides with win_valid rising for the last window.
  - It is not held by backpressure.
- Reset values:
  - win_valid=0, win_out=0, win_row=0, win_col=0, frame_done=0.
  - Counters (0,0); tap registers 0.
  - in_ready=1 the cycle after reset.
  - Reset mid-frame discards any pending window, and the next pixel is (0,0).

Test Plan:
1. IMG_W=4, IMG_H=4, pixel=r*4+c, in_valid always 1, win_ready=1.
   - Exactly 4 windows.
   - First window appears the cycle after pixel 10: taps 0,1,2,4,5,6,8,9,10, centre (1,1).
   - Last window: 5,6,7,9,10,11,13,14,15, centre (2,2).
   - frame_done pulses once, with the last window.
2. Same image, win_ready low for 5 cycles at the first window.
   - win_out stays 0,1,2,4,5,6,8,9,10 and in_ready=0 throughout.
   - No pixel is lost; all 4 windows match test 1.
3. Randomised in_valid/win_ready, IMG_W=8, IMG_H=6, two consecutive frames.
   - 24 windows per frame, each matching the golden 3x3 model.
   - Exactly two frame_done pulses.
4. in_sof asserted at frame pixel 9 of a 4x4 frame, followed by a complete frame.
   - No window from the aborted frame after the resync.
   - No frame_done for the aborted frame.
   - The new frame yields 4 correct windows.
5. rst asserted for one cycle while win_valid=1 and win_ready=0.
   - Next cycle: win_valid=0, in_ready=1, frame_done=0.
   - A following full frame is correct.
6. Line-boundary check, IMG_W=3, IMG_H=3.
   - Exactly one window, centre (1,1), taps 0..8.
   - No spurious window at column 0 or 1 of any row.
